// File: rtl/lc3_mem_ctrl.sv
// ============================================================================
//  Module      : lc3_mem_ctrl
//  Description : LC-3 CPU memory controller. Accepts one read or write
//                request at a time and serves it from a single-port BRAM
//                with one-cycle registered read data. Completion is a
//                one-cycle rsp_valid pulse.
//                Optional memory-mapped keyboard/display registers in
//                0xFE00-0xFFFF are enabled by defining LC3_MMIO_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_mem_ctrl #(
    parameter int ADDR = 12,
    parameter int DATA = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    // CPU request/response
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wr,
    input  logic [15:0]     req_addr,
    input  logic [DATA-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [DATA-1:0] rsp_rdata,
    // BRAM port
    output logic            mem_wr,
    output logic [ADDR-1:0] mem_addr,
    output logic [DATA-1:0] mem_din,
    input  logic [DATA-1:0] mem_dout,
    // Keyboard device
    input  logic            kbd_valid,
    input  logic [7:0]      kbd_data,
    output logic            kbd_ack,
    // Display device
    input  logic            dsp_ready,
    output logic            dsp_valid,
    output logic [7:0]      dsp_data
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR       = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t          state;
    logic [15:0]     addr_q;      // full LC-3 address of the access in flight
    logic [DATA-1:0] wdata_q;     // write data, echoed back on the response
    logic            dev_q;       // access in flight targets device space
    logic            is_dev;      // incoming request targets device space
    logic [DATA-1:0] dev_rdata;   // device register read value
    logic            unused_ok;

    wire accept = req_valid && req_ready;

    // Main access sequencer; all handshake and BRAM outputs are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            dev_q     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        dev_q     <= is_dev;
                        // Device accesses leave the BRAM port untouched
                        if (!is_dev) begin
                            mem_addr <= req_addr[ADDR-1:0];
                        end
                        if (req_wr) begin
                            state   <= WR;
                            mem_wr  <= !is_dev;
                            mem_din <= req_wdata;
                        end else begin
                            state <= RD_ISSUE;
                        end
                    end else begin
                        // Also raises ready on the first edge after reset
                        req_ready <= 1'b1;
                    end
                end
                RD_ISSUE: begin
                    // BRAM samples mem_addr at the end of this cycle
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= dev_q ? dev_rdata : mem_dout;
                end
                WR: begin
                    state     <= RESP;
                    mem_wr    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= wdata_q;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    mem_wr    <= 1'b0;
                end
            endcase
        end
    end

`ifdef LC3_MMIO_EN
    // 0xFE00-0xFFFF is device space
    assign is_dev = (req_addr[15:9] == 7'h7F);

    // Device register read mux, indexed by the latched address
    always_comb begin
        dev_rdata = '0;
        case (addr_q[8:0])
            9'h000:  dev_rdata[DATA-1] = kbd_valid;   // KBSR
            9'h002:  dev_rdata[7:0]    = kbd_data;    // KBDR
            9'h004:  dev_rdata[DATA-1] = dsp_ready;   // DSR
            default: dev_rdata = '0;
        endcase
    end

    // Keyboard acknowledge and display strobe, both aligned with RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbd_ack   <= 1'b0;
            dsp_valid <= 1'b0;
            dsp_data  <= '0;
        end else begin
            kbd_ack   <= (state == RD_WAIT) && dev_q && (addr_q[8:0] == 9'h002);
            dsp_valid <= (state == WR) && dev_q && (addr_q[8:0] == 9'h006);
            if ((state == WR) && dev_q && (addr_q[8:0] == 9'h006)) begin
                dsp_data <= wdata_q[7:0];
            end
        end
    end

    assign unused_ok = ^addr_q[15:9];
`else
    // Whole address space maps to BRAM; devices are inert
    assign is_dev    = 1'b0;
    assign dev_rdata = '0;
    assign kbd_ack   = 1'b0;
    assign dsp_valid = 1'b0;
    assign dsp_data  = '0;

    assign unused_ok = ^{addr_q, req_addr, kbd_valid, kbd_data, dsp_ready};
`endif

endmodule

`default_nettype wire

// File: tb/tb_lc3_mem_ctrl.sv
// ============================================================================
//  Module      : tb_lc3_mem_ctrl
//  Description : Self-checking bench for lc3_mem_ctrl with a behavioural
//                BRAM model and a queue of expected response data.
//                Device-space tests follow LC3_MMIO_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lc3_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        mem_wr;
    logic [11:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        kbd_ack;
    logic        dsp_ready;
    logic        dsp_valid;
    logic [7:0]  dsp_data;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    // Preload port for the BRAM model
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [15:0] pl_data = '0;

    // Monitor counters (written only by the monitor process)
    int n_kbd = 0, n_kbd_rsp = 0, n_dsp = 0, n_dsp_rsp = 0, n_memwr = 0;

    logic [15:0] pre [0:3];

    always #5 clk = ~clk;

    lc3_mem_ctrl #(.ADDR(12), .DATA(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_ack(kbd_ack),
        .dsp_ready(dsp_ready), .dsp_valid(dsp_valid), .dsp_data(dsp_data)
    );

    // BRAM model: registered read, one-cycle latency
    logic [15:0] mem [0:4095];
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_wr) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (kbd_ack) n_kbd++;
        if (kbd_ack && rsp_valid) n_kbd_rsp++;
        if (dsp_valid) n_dsp++;
        if (dsp_valid && rsp_valid) n_dsp_rsp++;
        if (mem_wr) n_memwr++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, ERRORS %0d", errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Present one request, push its expected data, and return at the
    // negedge where rsp_valid is seen. lat counts edges from the accept edge.
    task automatic do_req(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                          input logic [15:0] expd, output int lat, output logic [15:0] data,
                          output logic s_wr, output logic [11:0] s_addr, output logic [15:0] s_din);
        int n;
        @(negedge clk);
        req_wr = wr; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout addr=%h: req_ready never rose", a);
        end
        exp_q.push_back(expd);
        @(negedge clk);
        req_valid = 1'b0;
        s_wr = mem_wr; s_addr = mem_addr; s_din = mem_din;
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        data = rsp_rdata;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        kbd_valid = 1'b0; kbd_data = '0; dsp_ready = 1'b0;
        pre[0] = 16'hC0DE; pre[1] = 16'h1357; pre[2] = 16'hA5A5; pre[3] = 16'h7E81;
        for (int i = 0; i < 4; i++) preload(i[11:0], pre[i]);
        preload(12'h200, 16'h0F0F);
        preload(12'hE02, 16'h6666);
        preload(12'hE06, 16'h7777);
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, mem_wr, mem_addr, mem_din, kbd_ack, dsp_valid, dsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rsp_v=%b rdata=%h mem_wr=%b addr=%h din=%h ack=%b dv=%b dd=%h, required all 0",
                     req_ready, rsp_valid, rsp_rdata, mem_wr, mem_addr, mem_din, kbd_ack, dsp_valid, dsp_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_write_read;
        int lat; logic [15:0] d, e; logic sw; logic [11:0] sa; logic [15:0] sd;
        do_req(1'b1, 16'h0123, 16'hBEEF, 16'hBEEF, lat, d, sw, sa, sd);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d required 2", lat); end
        checks++;
        if (d !== e) begin errors++; $display("FAIL wr_echo: got %h required %h", d, e); end
        checks++;
        if ({sw, sa, sd} !== {1'b1, 12'h123, 16'hBEEF}) begin
            errors++; $display("FAIL wr_port: got wr=%b addr=%h din=%h required 1 123 beef", sw, sa, sd);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_pulse: got %b required 0", rsp_valid); end
        do_req(1'b0, 16'h0123, 16'h0000, 16'hBEEF, lat, d, sw, sa, sd);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d required 3", lat); end
        checks++;
        if (d !== e) begin errors++; $display("FAIL rd_data: got %h required %h", d, e); end
        checks++;
        if (sw !== 1'b0) begin errors++; $display("FAIL rd_mem_wr: got %b required 0", sw); end
    endtask

    task automatic test_back_to_back;
        int acc[4]; int nacc, nrsp; logic prev; logic [15:0] e;
        nacc = 0; nrsp = 0; prev = 1'b0;
        @(negedge clk);
        req_wr = 1'b0; req_addr = 16'h0000; req_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && nrsp < 4; cyc++) begin
            if (rsp_valid) begin
                e = exp_q.pop_front();
                checks++;
                if (rsp_rdata !== e) begin
                    errors++; $display("FAIL b2b_data[%0d]: got %h required %h", nrsp, rsp_rdata, e);
                end
                checks++;
                if (prev !== 1'b0) begin
                    errors++; $display("FAIL b2b_pulse[%0d]: rsp_valid high %0d cycles required 1", nrsp, 2);
                end
                nrsp++;
            end
            prev = rsp_valid;
            if (req_valid && req_ready) begin
                acc[nacc] = cyc;
                exp_q.push_back(pre[nacc]);
                nacc++;
            end
            @(negedge clk);
            if (nacc < 4) req_addr = 16'(nacc);
            else req_valid = 1'b0;
        end
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_last_pulse: got %b required 0", rsp_valid); end
        checks++;
        if (nacc !== 4 || nrsp !== 4) begin
            errors++; $display("FAIL b2b_count: accepts %0d responses %0d required 4 4", nacc, nrsp);
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (acc[i] - acc[i-1] !== 4) begin
                    errors++; $display("FAIL b2b_spacing[%0d]: got %0d required 4", i, acc[i] - acc[i-1]);
                end
            end
        end
    endtask

    task automatic test_alias;
        int lat; logic [15:0] d, e; logic sw; logic [11:0] sa; logic [15:0] sd;
        do_req(1'b1, 16'h1005, 16'h5555, 16'h5555, lat, d, sw, sa, sd);
        e = exp_q.pop_front();
        checks++;
        if ({sw, sa, sd} !== {1'b1, 12'h005, 16'h5555}) begin
            errors++; $display("FAIL alias_port: got wr=%b addr=%h din=%h required 1 005 5555", sw, sa, sd);
        end
        checks++;
        if (d !== e || lat !== 2) begin errors++; $display("FAIL alias_wr: got %h lat %0d required %h lat 2", d, lat, e); end
        do_req(1'b0, 16'h0005, 16'h0000, 16'h5555, lat, d, sw, sa, sd);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL alias_rd: got %h required %h", d, e); end
    endtask

    task automatic test_reset_during_write;
        int n, nrsp; int lat; logic [15:0] d, e; logic sw; logic [11:0] sa; logic [15:0] sd;
        @(negedge clk);
        req_wr = 1'b1; req_addr = 16'h0200; req_wdata = 16'h1234; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (mem_wr !== 1'b1) begin errors++; $display("FAIL rstwr_in_wr: mem_wr got %b required 1", mem_wr); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_wr !== 1'b0) begin errors++; $display("FAIL rstwr_mem_wr_drop: got %b required 0", mem_wr); end
        nrsp = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
            checks++;
            if (req_ready !== 1'b0) begin errors++; $display("FAIL rstwr_ready_in_reset: got %b required 0", req_ready); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (rsp_valid) nrsp++;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rstwr_ready_after: got %b required 1", req_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        checks++;
        if (nrsp !== 0) begin errors++; $display("FAIL rstwr_no_rsp: got %0d pulses required 0", nrsp); end
        do_req(1'b0, 16'h0200, 16'h0000, 16'h0F0F, lat, d, sw, sa, sd);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL rstwr_mem_kept: got %h required %h", d, e); end
    endtask

`ifdef LC3_MMIO_EN
    task automatic test_mmio;
        int lat; logic [15:0] d, e; logic sw; logic [11:0] sa; logic [15:0] sd;
        int k0, kr0, d0, dr0, w0;
        kbd_valid = 1'b1; kbd_data = 8'h41; dsp_ready = 1'b1;
        do_req(1'b0, 16'hFE00, 16'h0000, 16'h8000, lat, d, sw, sa, sd);
        e = exp_q.pop_front();
        checks++;
        if (d !== e || lat !== 3) begin errors++; $display("FAIL mmio_kbsr: got %h lat %0d required %h lat 3", d, lat, e); end
        k0 = n_kbd; kr0 = n_kbd_rsp;
        do_req(1'b0, 16'hFE02, 16'h0000, 16'h0041, lat, d, sw, sa, sd);
        e = exp_q.pop_front();
        @(negedge clk);
        checks++;
        if (d !== e || lat !== 3) begin errors++; $display("FAIL mmio_kbdr: got %h lat %0d required %h lat 3", d, lat, e); end
        checks++;
        if (n_kbd - k0 !== 1 || n_kbd_rsp - kr0 !== 1) begin
            errors++; $display("FAIL mmio_kbd_ack: got %0d cycles (%0d in RESP) required 1 1", n_kbd - k0, n_kbd_rsp - kr0);
        end
        do_req(1'b0, 16'hFE04, 16'h0000, 16'h8000, lat, d, sw, sa, sd);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL mmio_dsr: got %h required %h", d, e); end
        d0 = n_dsp; dr0 = n_dsp_rsp; w0 = n_memwr;
        do_req(1'b1, 16'hFE06, 16'h0048, 16'h0048, lat, d, sw, sa, sd);
        e = exp_q.pop_front();
        @(negedge clk);
        checks++;
        if (d !== e || lat !== 2) begin errors++; $display("FAIL mmio_ddr_rsp: got %h lat %0d required %h lat 2", d, lat, e); end
        checks++;
        if (dsp_data !== 8'h48) begin errors++; $display("FAIL mmio_dsp_data: got %h required 48", dsp_data); end
        checks++;
        if (n_dsp - d0 !== 1 || n_dsp_rsp - dr0 !== 1) begin
            errors++; $display("FAIL mmio_dsp_valid: got %0d cycles (%0d in RESP) required 1 1", n_dsp - d0, n_dsp_rsp - dr0);
        end
        checks++;
        if (n_memwr - w0 !== 0) begin errors++; $display("FAIL mmio_mem_wr: got %0d cycles required 0", n_memwr - w0); end
        do_req(1'b0, 16'h0E06, 16'h0000, 16'h7777, lat, d, sw, sa, sd);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL mmio_bram_untouched: got %h required %h", d, e); end
    endtask
`else
    task automatic test_no_mmio;
        int lat; logic [15:0] d, e; logic sw; logic [11:0] sa; logic [15:0] sd;
        int d0, k0;
        kbd_valid = 1'b1; kbd_data = 8'h41; dsp_ready = 1'b1;
        d0 = n_dsp; k0 = n_kbd;
        do_req(1'b1, 16'hFE06, 16'h0048, 16'h0048, lat, d, sw, sa, sd);
        e = exp_q.pop_front();
        checks++;
        if ({sw, sa, sd} !== {1'b1, 12'hE06, 16'h0048}) begin
            errors++; $display("FAIL nommio_port: got wr=%b addr=%h din=%h required 1 e06 0048", sw, sa, sd);
        end
        checks++;
        if (d !== e || lat !== 2) begin errors++; $display("FAIL nommio_wr: got %h lat %0d required %h lat 2", d, lat, e); end
        do_req(1'b0, 16'hFE02, 16'h0000, 16'h6666, lat, d, sw, sa, sd);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL nommio_rd_fe02: got %h required %h", d, e); end
        do_req(1'b0, 16'h0E06, 16'h0000, 16'h0048, lat, d, sw, sa, sd);
        e = exp_q.pop_front();
        @(negedge clk);
        checks++;
        if (d !== e) begin errors++; $display("FAIL nommio_rd_e06: got %h required %h", d, e); end
        checks++;
        if (n_dsp - d0 !== 0 || n_kbd - k0 !== 0 || dsp_data !== 8'h00) begin
            errors++; $display("FAIL nommio_devices: dsp_valid %0d kbd_ack %0d dsp_data %h required 0 0 00",
                               n_dsp - d0, n_kbd - k0, dsp_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_alias();
        test_reset_during_write();
`ifdef LC3_MMIO_EN
        test_mmio();
`else
        test_no_mmio();
`endif
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lc3_mem_ctrl.md
LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR, default 12, meaning BRAM word-address width (memory depth 2**ADDR words).
REQ-002 SHALL have parameter DATA, default 16, meaning data word width.
REQ-003 SHALL use one clock, clk (input, 1): all state changes on its rising edge.
REQ-004 SHALL use rst_n (input, 1): reset, asynchronous and active-low.
REQ-005 SHALL have req_valid (input, 1): CPU access request.
REQ-006 SHALL have req_ready (output, 1): controller accepts a request this cycle.
REQ-007 SHALL have req_wr (input, 1): 1 = write, 0 = read.
REQ-008 SHALL have req_addr (input, 16): LC-3 word address.
REQ-009 SHALL have req_wdata (input, DATA): write data.
REQ-010 SHALL have rsp_valid (output, 1): one-cycle completion pulse.
REQ-011 SHALL have rsp_rdata (output, DATA): read data, or echoed write data.
REQ-012 SHALL have mem_wr (output, 1): BRAM port write enable.
REQ-013 SHALL have mem_addr (output, ADDR): BRAM port address.
REQ-014 SHALL have mem_din (output, DATA): BRAM port write data.
REQ-015 SHALL have mem_dout (input, DATA): BRAM registered read data, one-cycle latency.
REQ-016 SHALL have kbd_valid (input, 1), kbd_data (input, 8) and kbd_ack (output, 1): keyboard device.
REQ-017 SHALL have dsp_ready (input, 1), dsp_valid (output, 1) and dsp_data (output, 8): display device.

Function
REQ-018 SHALL implement FSM states IDLE, RD_ISSUE, RD_WAIT, WR, RESP, all registered.
REQ-019 SHALL assert req_ready only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-020 SHALL, on an accepted read, latch the address and go IDLE->RD_ISSUE->RD_WAIT->RESP->IDLE, capturing mem_dout into rsp_rdata on the RD_WAIT->RESP edge.
REQ-021 SHALL, on an accepted write, go IDLE->WR->RESP->IDLE, with mem_wr=1, mem_addr and mem_din valid only during WR.
REQ-022 SHALL assert rsp_valid for exactly one cycle, in RESP: read = 3 cycles after the accept edge, write = 2 cycles after the accept edge; there is no response backpressure.
REQ-023 SHALL set rsp_rdata to req_wdata for writes; rsp_rdata SHALL hold its value until the next RESP.
REQ-024 SHALL drive mem_addr = req_addr[ADDR-1:0] (upper bits ignored, aliasing wraps).
REQ-025 SHALL hold mem_wr = 0 in every state except WR.
REQ-026 SHALL ignore req_valid outside IDLE, so back-to-back requests are accepted on the edge that enters IDLE+1 cycle after RESP.

Reset
REQ-027 SHALL, while rst_n = 0, force state IDLE and drive req_ready=0, rsp_valid=0, rsp_rdata=0, mem_wr=0, mem_addr=0, mem_din=0, kbd_ack=0, dsp_valid=0, dsp_data=0.
REQ-028 SHALL abort any in-flight access on reset with no response, and SHALL deassert mem_wr immediately when reset asserts during WR.
REQ-029 SHALL assert req_ready=1 from the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with LC3_MMIO_EN defined, decode req_addr 0xFE00-0xFFFF as device space, never reaching BRAM, and keep the same FSM path and latency as memory accesses.
REQ-031 SHALL, with LC3_MMIO_EN, implement the device registers as follows:
- read 0xFE00 (KBSR) = {kbd_valid,15'b0}
- read 0xFE02 (KBDR) = {8'b0,kbd_data}, with kbd_ack pulsed during RESP
- read 0xFE04 (DSR) = {dsp_ready,15'b0}
- write 0xFE06 (DDR): dsp_data <= req_wdata[7:0], with dsp_valid pulsed during RESP
- other device reads return 0; other device writes are dropped; mem_wr stays 0 for all of them.
REQ-032 SHALL, without LC3_MMIO_EN, map all addresses to BRAM, tie kbd_ack, dsp_valid and dsp_data to 0, and ignore the device inputs.

Verification
REQ-033 Bench SHALL cover: write 0x0123 <- 0xBEEF, then read 0x0123 -> rsp_valid 2 cycles after the write accept, then 3 cycles after the read accept with rsp_rdata=0xBEEF.
REQ-034 Bench SHALL cover: req_valid held high for 4 reads 0x0000-0x0003 -> accepts 4 cycles apart, each rsp_valid exactly one cycle, data matching preloaded memory.
REQ-035 Bench SHALL cover: write 0x1005 <- 0x5555 with ADDR=12 -> mem_addr=0x005, and a read of 0x0005 returns 0x5555.
REQ-036 Bench SHALL cover: rst_n pulsed low during WR -> mem_wr drops the same cycle, no rsp_valid, req_ready=1 one edge after release.
REQ-037 Bench SHALL cover, with LC3_MMIO_EN: kbd_valid=1, kbd_data=0x41, read 0xFE00 -> 0x8000; read 0xFE02 -> 0x0041 with a one-cycle kbd_ack; write 0xFE06 <- 0x0048 -> dsp_data=0x48 with a one-cycle dsp_valid and mem_wr never 1.
REQ-038 Bench SHALL cover, without LC3_MMIO_EN: write 0xFE06 <- 0x0048 -> mem_wr=1 at mem_addr=0xE06, and dsp_valid stays 0.
